// File: rtl/modulo_oposto_inverso.sv
// Converts a (W+1)-bit two's-complement operand into sign + W-bit magnitude, with a 2-entry output buffer.
// Latency: an operand accepted at edge N is on out_* right after edge N when the buffer is empty; 1 result/cycle sustained.
// Backpressure: in_ready is decoded from the registered occupancy only (low when both entries are full), never from out_ready.
//
// Ports:
//   clk, rst_n                  clock and synchronous active-low reset
//   in_valid/in_ready/in_dado   operand stream, in_dado is signed W+1 bits
//   out_valid/out_ready         result stream handshake
//   out_sinal/out_modulo/out_ovf  head entry: sign, |operand| saturated to 2^W-1, saturation flag
//   ovf_count                   saturation event counter, present only when MODULO_INVERSO_CONT_EN is defined
//
// Optional feature macro: MODULO_INVERSO_CONT_EN (adds parameter CONT_W and port ovf_count).

module modulo_oposto_inverso #(
    parameter int W = 8
`ifdef MODULO_INVERSO_CONT_EN
    ,
    parameter int CONT_W = 16
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   in_dado,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sinal,
    output logic [W-1:0] out_modulo,
    output logic         out_ovf
`ifdef MODULO_INVERSO_CONT_EN
    ,
    output logic [CONT_W-1:0] ovf_count
`endif
);

    typedef struct packed {
        logic         sinal;
        logic [W-1:0] modulo;
        logic         ovf;
    } entrada_t;

    typedef enum logic [1:0] {
        VAZIO = 2'd0,
        UM    = 2'd1,
        DOIS  = 2'd2
    } estado_t;

    estado_t  estado;
    estado_t  estado_prox;
    entrada_t cabeca;
    entrada_t cabeca_prox;
    entrada_t cauda;
    entrada_t cauda_prox;
    entrada_t conv;

    logic         push;
    logic         pop;
    logic [W-1:0] negado;

    // ------------------------------------------------------------------
    // Conversion at the input. The low W bits of the two's-complement
    // negation depend only on the low W bits of the operand, so the
    // negate is done at W bits. -2^W has no positive W-bit counterpart
    // and is saturated to all ones with ovf raised.
    // ------------------------------------------------------------------
    always_comb begin
        negado      = ~in_dado[W-1:0] + {{(W-1){1'b0}}, 1'b1};
        conv.sinal  = in_dado[W];
        conv.ovf    = (in_dado == {1'b1, {W{1'b0}}});
        if (conv.ovf) begin
            conv.modulo = {W{1'b1}};
        end else if (in_dado[W]) begin
            conv.modulo = negado;
        end else begin
            conv.modulo = in_dado[W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Handshake decode. rst_n gates in_ready so nothing is accepted
    // during a reset cycle regardless of the stale state register.
    // ------------------------------------------------------------------
    assign in_ready  = rst_n && (estado != DOIS);
    assign out_valid = (estado != VAZIO);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Occupancy FSM, next state and buffer contents.
    // cabeca is always the oldest entry; cauda only holds data in DOIS.
    // ------------------------------------------------------------------
    always_comb begin
        estado_prox = estado;
        cabeca_prox = cabeca;
        cauda_prox  = cauda;
        case (estado)
            VAZIO: begin
                if (push) begin
                    cabeca_prox = conv;
                    estado_prox = UM;
                end
            end
            UM: begin
                if (push && pop) begin
                    // Head leaves while the new entry arrives: new one becomes head.
                    cabeca_prox = conv;
                end else if (push) begin
                    cauda_prox  = conv;
                    estado_prox = DOIS;
                end else if (pop) begin
                    estado_prox = VAZIO;
                end
            end
            DOIS: begin
                // in_ready is low here, so a pop is the only possible event.
                if (pop) begin
                    cabeca_prox = cauda;
                    estado_prox = UM;
                end
            end
            default: begin
                estado_prox = VAZIO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado <= VAZIO;
            cabeca <= '0;
            cauda  <= '0;
        end else begin
            estado <= estado_prox;
            cabeca <= cabeca_prox;
            cauda  <= cauda_prox;
        end
    end

    // Fields are forced to zero while nothing valid is held, so a
    // discarded or stale entry is never visible on the outputs.
    always_comb begin
        out_sinal  = 1'b0;
        out_modulo = '0;
        out_ovf    = 1'b0;
        if (out_valid) begin
            out_sinal  = cabeca.sinal;
            out_modulo = cabeca.modulo;
            out_ovf    = cabeca.ovf;
        end
    end

`ifdef MODULO_INVERSO_CONT_EN
    // Counts accepted saturating operands; sticks at all ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (push && conv.ovf && (ovf_count != {CONT_W{1'b1}})) begin
            ovf_count <= ovf_count + {{(CONT_W-1){1'b0}}, 1'b1};
        end
    end
`else
`endif

endmodule
